tick_scheduler: RTL and testbench

Shared one-second timebase plus a bank of programmable countdown channels. A single prescaler divides `clk_in` into a one-cycle base tick. `CHANNELS` independent requesters each count that tick down through one shared configuration port. The block replaces per-requester clock dividers: consumers receive single-cycle `expire` enables in the `clk_in` domain instead of derived clocks.

---
 rtl/tick_scheduler.sv | 115 +++++++++++
 tb/tb_tick_scheduler.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/tick_scheduler.sv
// Shared base-tick prescaler feeding a bank of countdown channels that emit
// single-cycle expire enables in the clk_in domain.
module tick_scheduler #(
    parameter logic [31:0] DIVISOR  = 32'd100000000,
    parameter int          CHANNELS = 4,
    parameter int          CNT_W    = 16,
    localparam int         CHAN_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk_in,
    input  logic                rst_n,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CHAN_W-1:0]   cfg_chan,
    input  logic [CNT_W-1:0]    cfg_count,
    input  logic                cfg_periodic,
    input  logic                cfg_stop,
    output logic                tick_out,
    output logic [CHANNELS-1:0] expire,
    output logic [CHANNELS-1:0] active
);

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_RUN  = 1'b1
    } chan_state_e;

    logic [31:0]          cnt_q, cnt_d;
    logic                 tick_q, tick_d;
    logic                 ready_q;
    logic [CHANNELS-1:0]  expire_q, expire_d;
    logic                 cfg_fire;

    chan_state_e          state_q  [CHANNELS];
    chan_state_e          state_d  [CHANNELS];
    logic [CNT_W-1:0]     reload_q [CHANNELS];
    logic [CNT_W-1:0]     reload_d [CHANNELS];
    logic [CNT_W-1:0]     remain_q [CHANNELS];
    logic [CNT_W-1:0]     remain_d [CHANNELS];
    logic                 per_q    [CHANNELS];
    logic                 per_d    [CHANNELS];

    // cfg handshake: a request transfers on any rising edge with
    // cfg_valid && cfg_ready; cfg_ready holds high from the first edge after
    // reset, so one config can transfer every cycle.
    assign cfg_fire  = cfg_valid && ready_q;
    assign cfg_ready = ready_q;
    assign tick_out  = tick_q;
    assign expire    = expire_q;

    always_comb begin
        cnt_d  = (cnt_q == DIVISOR - 32'd1) ? 32'd0 : cnt_q + 32'd1;
        tick_d = (cnt_q == DIVISOR - 32'd1);
    end

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i]  = state_q[i];
            reload_d[i] = reload_q[i];
            remain_d[i] = remain_q[i];
            per_d[i]    = per_q[i];
            expire_d[i] = 1'b0;
            active[i]   = (state_q[i] == CH_RUN);

            // A config on this channel swallows a coincident tick entirely.
            if (cfg_fire && (cfg_chan == CHAN_W'(i))) begin
                if (cfg_stop || (cfg_count == '0)) begin
                    state_d[i] = CH_IDLE;
                end else begin
                    state_d[i]  = CH_RUN;
                    reload_d[i] = cfg_count;
                    remain_d[i] = cfg_count;
                    per_d[i]    = cfg_periodic;
                end
            end else if (tick_q && (state_q[i] == CH_RUN)) begin
                if (remain_q[i] > CNT_W'(1)) begin
                    remain_d[i] = remain_q[i] - CNT_W'(1);
                end else begin
                    expire_d[i] = 1'b1;
                    if (per_q[i]) begin
                        remain_d[i] = reload_q[i];
                    end else begin
                        state_d[i] = CH_IDLE;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= 32'd0;
            tick_q   <= 1'b0;
            ready_q  <= 1'b0;
            expire_q <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i]  <= CH_IDLE;
                reload_q[i] <= '0;
                remain_q[i] <= '0;
                per_q[i]    <= 1'b0;
            end
        end else begin
            cnt_q    <= cnt_d;
            tick_q   <= tick_d;
            ready_q  <= 1'b1;
            expire_q <= expire_d;
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i]  <= state_d[i];
                reload_q[i] <= reload_d[i];
                remain_q[i] <= remain_d[i];
                per_q[i]    <= per_d[i];
            end
        end
    end

endmodule

// File: tb/tb_tick_scheduler.sv
// Bench for tick_scheduler: expiries are predicted from the acceptance edge and
// queued, then matched against the expire outputs edge by edge.
module tb_tick_scheduler;

    localparam logic [31:0] D    = 32'd4;
    localparam int          CH   = 5;
    localparam int          CW   = 16;
    localparam int          SB_W = 20;

    logic          clk_in;
    logic          rst_n;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [2:0]    cfg_chan;
    logic [CW-1:0] cfg_count;
    logic          cfg_periodic;
    logic          cfg_stop;
    logic          tick_out;
    logic [CH-1:0] expire;
    logic [CH-1:0] active;

    int n_tests;
    int n_fail;
    int edge_n;
    logic [SB_W-1:0] exp_q[$];
    logic [SB_W-1:0] obs_v;
    logic [SB_W-1:0] exp_v;

    tick_scheduler #(
        .DIVISOR  (D),
        .CHANNELS (CH),
        .CNT_W    (CW)
    ) dut (
        .clk_in       (clk_in),
        .rst_n        (rst_n),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_chan     (cfg_chan),
        .cfg_count    (cfg_count),
        .cfg_periodic (cfg_periodic),
        .cfg_stop     (cfg_stop),
        .tick_out     (tick_out),
        .expire       (expire),
        .active       (active)
    );

    // clock / reset
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    always @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) edge_n = 0;
        else        edge_n = edge_n + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached at edge %0d", edge_n);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", tag, edge_n, got, exp);
        end
    endtask

    // Edge at which the N-th (x k) consumed tick after acceptance edge e lands.
    function automatic int exp_edge(input int e, input int n, input int k);
        int first;
        first = (e / int'(D)) * int'(D) + 1;
        if (first <= e) first += int'(D);
        if (first < int'(D) + 1) first = int'(D) + 1;
        return first + (k * n - 1) * int'(D);
    endfunction

    task automatic sb_push(input int e, input int ch);
        logic [SB_W-1:0] v;
        int idx;
        v = {e[15:0], 4'(ch)};
        idx = 0;
        while (idx < exp_q.size() && exp_q[idx] < v) idx++;
        exp_q.insert(idx, v);
    endtask

    // driver tasks
    task automatic cfg_at(input int e, input int ch, input int cnt, input logic per, input logic stp);
        while (edge_n < e - 1) @(negedge clk_in);
        cfg_valid    = 1'b1;
        cfg_chan     = 3'(ch);
        cfg_count    = CW'(cnt);
        cfg_periodic = per;
        cfg_stop     = stp;
        @(posedge clk_in);
        #1;
        cfg_valid    = 1'b0;
        cfg_stop     = 1'b0;
        cfg_periodic = 1'b0;
        cfg_count    = CW'($urandom_range(0, 65535));
        cfg_chan     = 3'($urandom_range(0, 7));
    endtask

    task automatic at_edge(input int k);
        do begin
            @(posedge clk_in);
            #1;
        end while (edge_n < k);
    endtask

    // scoreboard monitor
    always @(negedge clk_in) begin
        if (rst_n) begin
            check("tick_out", 32'(tick_out), 32'((edge_n > 0) && (edge_n % int'(D) == 0)));
            check("cfg_ready", 32'(cfg_ready), 32'(edge_n >= 1));
            for (int i = 0; i < CH; i++) begin
                if (expire[i]) begin
                    obs_v = {edge_n[15:0], 4'(i)};
                    if (exp_q.size() == 0) begin
                        check("expire_unexpected", 32'(obs_v), 32'hFFFF_FFFF);
                    end else begin
                        exp_v = exp_q.pop_front();
                        check("expire", 32'(obs_v), 32'(exp_v));
                    end
                end
            end
        end
    end

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        cfg_valid    = 1'b0;
        cfg_chan     = '0;
        cfg_count    = '0;
        cfg_periodic = 1'b0;
        cfg_stop     = 1'b0;

        @(negedge clk_in);
        @(negedge clk_in);
        check("rst_tick", 32'(tick_out), 32'd0);
        check("rst_expire", 32'(expire), 32'd0);
        check("rst_active", 32'(active), 32'd0);
        check("rst_ready", 32'(cfg_ready), 32'd0);
        rst_n = 1'b1;

        // one-shot, periodic and a config landing on a tick edge
        cfg_at(2, 0, 3, 1'b0, 1'b0);
        sb_push(exp_edge(2, 3, 1), 0);
        check("act_e2", 32'(active), 32'b00001);
        cfg_at(3, 1, 2, 1'b1, 1'b0);
        for (int k = 1; k <= 3; k++) sb_push(exp_edge(3, 2, k), 1);
        check("act_e3", 32'(active), 32'b00011);
        cfg_at(5, 2, 1, 1'b0, 1'b0);
        sb_push(exp_edge(5, 1, 1), 2);
        check("act_e5", 32'(active), 32'b00111);
        at_edge(9);
        check("act_e9", 32'(active), 32'b00011);
        at_edge(12);
        check("act_e12", 32'(active), 32'b00011);
        at_edge(13);
        check("act_e13", 32'(active), 32'b00010);

        // stop, count 0 and out-of-range channels
        cfg_at(26, 1, 0, 1'b0, 1'b1);
        check("act_stop", 32'(active), 32'b00000);
        cfg_at(27, 3, 5, 1'b1, 1'b0);
        check("act_e27", 32'(active), 32'b01000);
        cfg_at(28, 3, 0, 1'b1, 1'b0);
        check("act_cnt0", 32'(active), 32'b00000);
        cfg_at(29, 2, 2, 1'b0, 1'b0);
        sb_push(exp_edge(29, 2, 1), 2);
        check("act_e29", 32'(active), 32'b00100);
        cfg_at(30, 5, 1, 1'b1, 1'b0);
        check("act_chan5", 32'(active), 32'b00100);
        cfg_at(31, 7, 3, 1'b0, 1'b1);
        check("act_chan7", 32'(active), 32'b00100);
        at_edge(37);
        check("act_e37", 32'(active), 32'b00000);
        at_edge(40);
        check("sb_drain", 32'(exp_q.size()), 32'd0);

        // async reset while channel 0 sits at remaining == 1
        cfg_at(41, 0, 2, 1'b1, 1'b0);
        check("act_e41", 32'(active), 32'b00001);
        at_edge(46);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_active", 32'(active), 32'd0);
        check("arst_expire", 32'(expire), 32'd0);
        check("arst_tick", 32'(tick_out), 32'd0);
        check("arst_ready", 32'(cfg_ready), 32'd0);
        @(negedge clk_in);
        @(negedge clk_in);
        rst_n = 1'b1;
        at_edge(20);
        check("arst_active_after", 32'(active), 32'd0);
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
